// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-addressed PC, early j/jal predecode, and the F/D pipeline latch.
// Redirects flush the latch to a bubble; stalls freeze the PC and the latch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [11:0] address_imem,
    input  logic [31:0] q_imem,
    output logic [31:0] fd_instruction,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_pc_plus1,
    output logic        fd_valid,
    output logic [31:0] pc
);

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_JAL = 5'b00011;

    logic [4:0]  opcode;
    logic [26:0] target;
    logic        early_jump;
    logic [31:0] pc_seq;
    logic [31:0] pc_fetch_next;

    assign address_imem = pc[11:0];

    assign opcode     = q_imem[31:27];
    assign target     = q_imem[26:0];
    assign early_jump = (opcode == OP_J) || (opcode == OP_JAL);
    assign pc_seq     = pc + 32'd1;

    // Jump targets are absolute within the low 27 bits; the upper PC bits clear.
    always_comb begin
        pc_fetch_next = pc_seq;
        if (early_jump) begin
            pc_fetch_next = {5'b0, target};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc             <= RESET_PC;
            fd_instruction <= NOP_WORD;
            fd_pc          <= 32'd0;
            fd_pc_plus1    <= 32'd0;
            fd_valid       <= 1'b0;
        end else if (redirect) begin
            pc             <= redirect_pc;
            fd_instruction <= NOP_WORD;
            fd_pc          <= 32'd0;
            fd_pc_plus1    <= 32'd0;
            fd_valid       <= 1'b0;
        end else if (!stall) begin
            // The jump itself is still latched so a jal can link from fd_pc_plus1.
            pc             <= pc_fetch_next;
            fd_instruction <= q_imem;
            fd_pc          <= pc;
            fd_pc_plus1    <= pc_seq;
            fd_valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a transaction-level fetch model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic [31:0] fd_instruction;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc_plus1;
    logic        fd_valid;
    logic [31:0] pc;

    logic [31:0] mem [0:4095];

    int total = 0;
    int bad   = 0;

    // Model state
    logic [31:0] m_pc, m_fi, m_fpc, m_fpc1;
    logic        m_fv;
    bit          model_ok = 1'b0;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .address_imem   (address_imem),
        .q_imem         (q_imem),
        .fd_instruction (fd_instruction),
        .fd_pc          (fd_pc),
        .fd_pc_plus1    (fd_pc_plus1),
        .fd_valid       (fd_valid),
        .pc             (pc)
    );

    always #5 clock = ~clock;

    assign q_imem = mem[address_imem];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one fetch transaction per edge, decided from the priority rules.
    always @(posedge clock) begin
        logic [31:0] w;
        w = mem[m_pc[11:0]];
        if (reset) begin
            m_pc = 32'd0; m_fi = 32'd0; m_fpc = 32'd0; m_fpc1 = 32'd0; m_fv = 1'b0;
            model_ok = 1'b1;
        end else if (redirect) begin
            m_pc = redirect_pc; m_fi = 32'd0; m_fpc = 32'd0; m_fpc1 = 32'd0; m_fv = 1'b0;
        end else if (!stall) begin
            m_fi   = w;
            m_fpc  = m_pc;
            m_fpc1 = m_pc + 32'd1;
            m_fv   = 1'b1;
            if (w[31:27] == 5'd1 || w[31:27] == 5'd3) m_pc = {5'b0, w[26:0]};
            else                                      m_pc = m_pc + 32'd1;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("m_pc",    pc,             m_pc);
            chk("m_addr",  {20'd0, address_imem}, {20'd0, m_pc[11:0]});
            chk("m_instr", fd_instruction, m_fi);
            chk("m_fdpc",  fd_pc,          m_fpc);
            chk("m_fdpc1", fd_pc_plus1,    m_fpc1);
            chk("m_valid", {31'd0, fd_valid}, {31'd0, m_fv});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 32'h1000_0000 + k;
        reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h55;
        step(2);
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", {31'd0, fd_valid}, 32'd0);
        chk("rst_instr", fd_instruction, 32'd0);
        chk("rst_fdpc1", fd_pc_plus1, 32'd0);

        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        step(1);
        chk("seq0_fdpc", fd_pc, 32'd0);
        chk("seq0_valid", {31'd0, fd_valid}, 32'd1);
        step(3);
        chk("seq3_fdpc", fd_pc, 32'd3);
        chk("seq3_instr", fd_instruction, 32'h1000_0003);
        chk("seq3_pc", pc, 32'd4);

        step(1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall_pc", pc, 32'd5);
            chk("stall_fdpc", fd_pc, 32'd4);
        end
        stall = 1'b0;
        step(1);
        chk("resume_fdpc", fd_pc, 32'd5);
        chk("resume_instr", fd_instruction, 32'h1000_0005);

        mem[2] = 32'h0800_0040;
        mem[7] = 32'h1800_0010;
        redirect = 1'b1; redirect_pc = 32'd2;
        step(1);
        redirect = 1'b0;
        step(1);
        chk("j_pc", pc, 32'h40);
        chk("j_fdpc", fd_pc, 32'd2);
        chk("j_instr", fd_instruction, 32'h0800_0040);
        step(1);
        chk("j_noskip", fd_pc, 32'h40);

        redirect = 1'b1; redirect_pc = 32'd7;
        step(1);
        redirect = 1'b0;
        step(1);
        chk("jal_pc", pc, 32'h10);
        chk("jal_fdpc1", fd_pc_plus1, 32'd8);
        chk("jal_valid", {31'd0, fd_valid}, 32'd1);

        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
        step(1);
        chk("rs_pc", pc, 32'h20);
        chk("rs_valid", {31'd0, fd_valid}, 32'd0);
        chk("rs_instr", fd_instruction, 32'd0);
        redirect = 1'b0;
        step(1);
        chk("bubble_hold", {31'd0, fd_valid}, 32'd0);
        stall = 1'b0;
        step(1);
        chk("rs_fdpc", fd_pc, 32'h20);

        redirect = 1'b1; redirect_pc = pc;
        step(1);
        chk("same_flush", {31'd0, fd_valid}, 32'd0);
        chk("same_pc", pc, 32'h21);

        redirect_pc = 32'hFFFF_FFFF;
        step(1);
        redirect = 1'b0;
        chk("wrap_addr_hi", {20'd0, address_imem}, 32'hFFF);
        step(1);
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_addr_lo", {20'd0, address_imem}, 32'd0);
        chk("wrap_fdpc", fd_pc, 32'hFFFF_FFFF);

        step(2);
        reset = 1'b1;
        step(1);
        chk("mid_rst_valid", {31'd0, fd_valid}, 32'd0);
        reset = 1'b0;
        step(1);
        chk("mid_rst_fdpc", fd_pc, 32'd0);
        chk("mid_rst_v", {31'd0, fd_valid}, 32'd1);

        for (int i = 0; i < 60; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom_range(0, 31);
            step(1);
        end
        stall = 1'b0; redirect = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
